// File: rtl/spike_gen.sv
// spike_gen: integrate-and-fire stage fed by the partial-sum combine block.
// Each accepted packet adds its psum into one neuron's membrane potential,
// fires when the potential reaches THRESH, and emits a spike/residual packet.
// After NUM_TS full timesteps every potential is cleared, one entry per cycle.

module spike_gen #(
    parameter int unsigned PACKET_D_WIDTH = 40,
    parameter int unsigned WIDTH_O        = 13,
    parameter int unsigned DEPTH_O        = 21,
    parameter int unsigned MEM_W          = 14,
    parameter int unsigned THRESH         = 64,
    parameter int unsigned NUM_TS         = 8,
    parameter logic [7:0]  OUT_HDR        = 8'hA0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PACKET_D_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACKET_D_WIDTH-1:0] out_data,
    output logic                      ts_done,
    output logic                      idx_err
);

    // Packet field widths are fixed by the packet format.
    localparam int unsigned IDX_W = 5;
    localparam int unsigned TS_W  = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_O - 1);
    localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(NUM_TS - 1);
    localparam logic [MEM_W-1:0] THRESH_V = MEM_W'(THRESH);
    localparam logic [MEM_W-1:0] POT_MAX  = {MEM_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StSend,
        StClear
    } state_e;

    state_e state_q, state_d;

    logic [MEM_W-1:0]          pot_q [DEPTH_O];
    logic [MEM_W-1:0]          pot_d [DEPTH_O];
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [WIDTH_O-1:0]        psum_q, psum_d;
    logic [IDX_W-1:0]          pkt_cnt_q, pkt_cnt_d;
    logic [TS_W-1:0]           ts_q, ts_d;
    logic [IDX_W-1:0]          clr_q, clr_d;
    logic [PACKET_D_WIDTH-1:0] out_data_q, out_data_d;
    logic                      ts_done_q, ts_done_d;
    logic                      idx_err_q, idx_err_d;

    // Input packet fields.
    logic [IDX_W-1:0]   in_idx;
    logic [WIDTH_O-1:0] in_psum;
    assign in_idx  = in_data[20:16];
    assign in_psum = in_data[WIDTH_O-1:0];

    logic unused_in_bits;
    assign unused_in_bits = ^{in_data[PACKET_D_WIDTH-1:21], in_data[15:WIDTH_O]};

    // Integrate datapath: one extra bit catches overflow for saturation.
    logic [MEM_W:0]   sum_ext;
    logic [MEM_W-1:0] sum_sat;
    logic             spike;
    logic [MEM_W-1:0] residual;

    // Saturating accumulate and threshold compare for the latched neuron.
    always_comb begin
        sum_ext  = {1'b0, pot_q[idx_q]} + {{(MEM_W + 1 - WIDTH_O){1'b0}}, psum_q};
        sum_sat  = sum_ext[MEM_W] ? POT_MAX : sum_ext[MEM_W-1:0];
        spike    = (sum_sat >= THRESH_V);
        residual = spike ? (sum_sat - THRESH_V) : sum_sat;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d    = state_q;
        pot_d      = pot_q;
        idx_d      = idx_q;
        psum_d     = psum_q;
        pkt_cnt_d  = pkt_cnt_q;
        ts_d       = ts_q;
        clr_d      = clr_q;
        out_data_d = out_data_q;
        ts_done_d  = 1'b0;
        idx_err_d  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated so nothing is accepted while reset is held.
                in_ready = ~reset;
                if (in_valid && !reset) begin
                    if (in_idx > LAST_IDX) begin
                        // Out-of-range neuron: drop the packet, flag it, stay idle.
                        idx_err_d = 1'b1;
                    end else begin
                        idx_d   = in_idx;
                        psum_d  = in_psum;
                        state_d = StCalc;
                    end
                end
            end

            StCalc: begin
                pot_d[idx_q] = residual;
                // ts here is the timestep this packet belongs to.
                out_data_d   = {OUT_HDR, 2'b00, ts_q, idx_q, spike,
                                {(21 - MEM_W){1'b0}}, residual};
                state_d      = StSend;
            end

            StSend: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (pkt_cnt_q == LAST_IDX) begin
                        pkt_cnt_d = '0;
                        ts_d      = ts_q + TS_W'(1);
                        if (ts_q == LAST_TS) begin
                            clr_d   = '0;
                            state_d = StClear;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + IDX_W'(1);
                        state_d   = StIdle;
                    end
                end
            end

            StClear: begin
                pot_d[clr_q] = '0;
                if (clr_q == LAST_IDX) begin
                    ts_d      = '0;
                    ts_done_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    clr_d = clr_q + IDX_W'(1);
                end
            end
        endcase
    end

    // Potential array, counters, output packet and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_O); i++) begin
                pot_q[i] <= '0;
            end
            idx_q      <= '0;
            psum_q     <= '0;
            pkt_cnt_q  <= '0;
            ts_q       <= '0;
            clr_q      <= '0;
            out_data_q <= '0;
            ts_done_q  <= 1'b0;
            idx_err_q  <= 1'b0;
        end else begin
            pot_q      <= pot_d;
            idx_q      <= idx_d;
            psum_q     <= psum_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ts_q       <= ts_d;
            clr_q      <= clr_d;
            out_data_q <= out_data_d;
            ts_done_q  <= ts_done_d;
            idx_err_q  <= idx_err_d;
        end
    end

    assign out_data = out_data_q;
    assign ts_done  = ts_done_q;
    assign idx_err  = idx_err_q;

endmodule
